// File: rtl/axi_read_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the fetch, load and memory sides.
interface axi_read_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  // Initiator of read transactions.
  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  // Responder to read transactions.
  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-to-one round-robin AXI4-Lite read arbiter: instruction fetch (imem) and data loads
// (dmem) share one memory read port, one outstanding transaction at a time.
module axi_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  axi_read_arbiter_if.slave  imem_axi,
  axi_read_arbiter_if.slave  dmem_axi,
  axi_read_arbiter_if.master mem_axi
);
  localparam logic [DATA_WIDTH-1:0] ZeroData = '0;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                r_state;
  logic                  r_grant;       // 0: imem, 1: dmem
  logic                  r_last_grant;  // master served by the last completed transaction
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [2:0]            r_arprot;
  logic                  r_arvalid;

  logic w_req_any;
  logic w_pick_dmem;
  logic w_addr_phase;
  logic w_data_phase;
  logic w_own_imem;
  logic w_own_dmem;
  logic w_mem_rready;

  // Round-robin pick: a lone requester wins; on a tie the master not served last wins.
  always_comb begin
    w_req_any    = imem_axi.arvalid | dmem_axi.arvalid;
    w_pick_dmem  = dmem_axi.arvalid & (~imem_axi.arvalid | ~r_last_grant);
    w_addr_phase = (r_state == StAddr);
    w_data_phase = (r_state == StData);
    w_own_imem   = ~r_grant;
    w_own_dmem   = r_grant;
    w_mem_rready = w_data_phase & (r_grant ? dmem_axi.rready : imem_axi.rready);
  end

  // Arbitration FSM; the AR request toward memory is fully registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_araddr     <= '0;
      r_arprot     <= '0;
      r_arvalid    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req_any) begin
            r_grant   <= w_pick_dmem;
            r_araddr  <= w_pick_dmem ? dmem_axi.araddr : imem_axi.araddr;
            r_arprot  <= w_pick_dmem ? dmem_axi.arprot : imem_axi.arprot;
            r_arvalid <= 1'b1;
            r_state   <= StAddr;
          end
        end
        StAddr: begin
          if (mem_axi.arready) begin
            r_arvalid <= 1'b0;
            r_state   <= StData;
          end
        end
        StData: begin
          // Re-arbitration waits for the next IDLE cycle, leaving one bubble.
          if (mem_axi.rvalid && w_mem_rready) begin
            r_last_grant <= r_grant;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Route handshakes and read data to the granted master only; the other sees zeros.
  always_comb begin
    mem_axi.araddr   = r_araddr;
    mem_axi.arprot   = r_arprot;
    mem_axi.arvalid  = r_arvalid;
    mem_axi.rready   = w_mem_rready;

    imem_axi.arready = w_addr_phase & w_own_imem & mem_axi.arready;
    dmem_axi.arready = w_addr_phase & w_own_dmem & mem_axi.arready;

    imem_axi.rvalid  = w_data_phase & w_own_imem & mem_axi.rvalid;
    imem_axi.rdata   = (w_data_phase & w_own_imem) ? mem_axi.rdata : ZeroData;
    imem_axi.rresp   = (w_data_phase & w_own_imem) ? mem_axi.rresp : 2'b00;

    dmem_axi.rvalid  = w_data_phase & w_own_dmem & mem_axi.rvalid;
    dmem_axi.rdata   = (w_data_phase & w_own_dmem) ? mem_axi.rdata : ZeroData;
    dmem_axi.rresp   = (w_data_phase & w_own_dmem) ? mem_axi.rresp : 2'b00;
  end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-to-one AXI4-Lite read-channel arbiter. Instruction fetch (imem) and data loads (dmem, driven by the EX stage) share one memory read port.
- Round-robin grant, one outstanding transaction at a time, registered request path.
- Sits between the IF/EX stages and the unified memory slave. The write channels bypass this block.

Parameters:
ADDR_WIDTH, 32, address width of all AR channels
DATA_WIDTH, 32, data width of all R channels

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
imem_axi_araddr  in  ADDR_WIDTH  fetch read address
imem_axi_arprot  in  3  fetch protection bits
imem_axi_arvalid  in  1  fetch address valid
imem_axi_arready  out  1  fetch address accepted
imem_axi_rdata  out  DATA_WIDTH  fetch read data
imem_axi_rresp  out  2  fetch read response
imem_axi_rvalid  out  1  fetch data valid
imem_axi_rready  in  1  fetch data accepted
dmem_axi_araddr  in  ADDR_WIDTH  load read address
dmem_axi_arprot  in  3  load protection bits
dmem_axi_arvalid  in  1  load address valid
dmem_axi_arready  out  1  load address accepted
dmem_axi_rdata  out  DATA_WIDTH  load read data
dmem_axi_rresp  out  2  load read response
dmem_axi_rvalid  out  1  load data valid
dmem_axi_rready  in  1  load data accepted
mem_axi_araddr  out  ADDR_WIDTH  slave read address
mem_axi_arprot  out  3  slave protection bits
mem_axi_arvalid  out  1  slave address valid
mem_axi_arready  in  1  slave address accepted
mem_axi_rdata  in  DATA_WIDTH  slave read data
mem_axi_rresp  in  2  slave read response
mem_axi_rvalid  in  1  slave data valid
mem_axi_rready  out  1  slave data accepted

Behaviour:

Reset:
- state=IDLE, grant=0, last_grant=1 (dmem), so imem wins the first tie.
- All outputs 0: mem_axi_araddr/arprot/arvalid/rready, both arready, both rvalid, both rdata, both rresp.
- Reset mid-transaction returns to IDLE immediately. No pending response is forwarded after reset.

FSM states: IDLE, ADDR, DATA.

IDLE:
- If exactly one master asserts arvalid, grant it.
- If both assert arvalid, grant the master not equal to last_grant.
- On grant, latch grant plus that master's araddr/arprot into output registers, set mem_axi_arvalid=1, go to ADDR.
- With no request, stay in IDLE.
- Latency: master arvalid in cycle N gives mem_axi_arvalid=1 in cycle N+1.

ADDR:
- mem_axi_arvalid=1; address and prot held stable.
- Granted master's arready = mem_axi_arready (combinational). Non-granted arready=0.
- On mem_axi_arvalid && mem_axi_arready: clear mem_axi_arvalid, go to DATA.
- A master never sees arready in IDLE. Its arready handshake coincides with the slave handshake.

DATA:
- Granted master sees rdata/rresp/rvalid = mem_axi_* and drives mem_axi_rready = its rready (combinational pass-through).
- Non-granted master: rvalid=0, rdata=0, rresp=0.
- On mem_axi_rvalid && mem_axi_rready: last_grant=grant, go to IDLE.
- Re-arbitration happens in the following IDLE cycle, so there is one bubble cycle between transactions.
- mem_axi_rresp is forwarded unmodified (SLVERR/DECERR included). The arbiter does not interpret it.

Fairness and stability:
- With both masters continuously requesting, grants strictly alternate.
- A request arriving from the other master during ADDR/DATA is held off (arready=0) and serviced next.
- A requesting master must keep arvalid/araddr stable (AXI rule). Withdrawing arvalid before grant is tolerated: no grant is issued.

Test Plan:
- Reset, then imem araddr=0x00000100 arvalid=1 → cycle+1 mem_axi_araddr=0x100, arvalid=1. Slave arready=1 → imem_axi_arready=1 same cycle. Slave rdata=0xDEADBEEF rvalid=1 → imem_axi_rdata=0xDEADBEEF, dmem_axi_rvalid=0.
- Both arvalid in the same cycle after reset (imem 0x200, dmem 0x8000_0040) → imem granted first, then dmem. mem_axi_araddr order is 0x200, 0x80000040.
- Both requesting continuously for 6 transactions → grant order imem, dmem, imem, dmem, imem, dmem. One idle cycle between each R handshake and the next mem_axi_arvalid.
- Slave stalls arready for 3 cycles, then rvalid with rready=0 for 2 cycles → araddr/arvalid held constant. Granted rvalid held; mem_axi_rready=0 until master rready=1, then return to IDLE.
- Slave returns rresp=2'b10 for a dmem load at 0x4 → dmem_axi_rresp=2'b10. Arbitration continues normally.
- Assert reset while in DATA → next cycle all outputs 0, state IDLE. A subsequent dmem request is granted (last_grant=1 after reset, imem idle).
